// File: rtl/id_ex_pipe_reg_if.sv
// Handshake and payload bundle between decode, the ID/EX register and execute.
// The master side is decode plus execute; the slave side is the register itself.
interface id_ex_pipe_reg_if #(
  parameter int XLEN   = 64,
  parameter int WR_W   = 5,
  parameter int CTRL_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   rd1;
  logic [XLEN-1:0]   rd2;
  logic [XLEN-1:0]   imm_gen;
  logic [WR_W-1:0]   wr;
  logic [CTRL_W-1:0] ctrl;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   pc_reg;
  logic [XLEN-1:0]   rd1_reg;
  logic [XLEN-1:0]   rd2_reg;
  logic [XLEN-1:0]   imm_gen_reg;
  logic [WR_W-1:0]   wr_reg;
  logic [CTRL_W-1:0] ctrl_reg;

  modport master (
    output in_valid, pc, rd1, rd2, imm_gen, wr, ctrl, out_ready,
    input  in_ready, out_valid, pc_reg, rd1_reg, rd2_reg, imm_gen_reg, wr_reg, ctrl_reg
  );

  modport slave (
    input  in_valid, pc, rd1, rd2, imm_gen, wr, ctrl, out_ready,
    output in_ready, out_valid, pc_reg, rd1_reg, rd2_reg, imm_gen_reg, wr_reg, ctrl_reg
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: valid/ready handshake over a two-entry (main + skid)
// buffer, synchronous flush, and a saturating back-pressure cycle counter.
module id_ex_pipe_reg #(
  parameter int XLEN   = 64,
  parameter int WR_W   = 5,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  id_ex_pipe_reg_if.slave  bus,
  input  logic             flush,
  input  logic             stall_cnt_clr,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [WR_W-1:0]   wr;
    logic [CTRL_W-1:0] ctrl;
  } payload_t;

  payload_t         main_r;
  payload_t         skid_r;
  payload_t         main_nxt_s;
  payload_t         skid_nxt_s;
  payload_t         in_beat_s;
  logic             main_valid_r;
  logic             skid_valid_r;
  logic             main_valid_nxt_s;
  logic             skid_valid_nxt_s;
  logic             accept_s;
  logic             consume_s;
  logic             stall_s;
  logic [CNT_W-1:0] stall_cnt_r;

  assign in_beat_s = {bus.pc, bus.rd1, bus.rd2, bus.imm_gen, bus.wr, bus.ctrl};

  // in_ready depends only on the skid valid flop, never on this cycle's inputs
  assign bus.in_ready    = ~skid_valid_r;
  assign bus.out_valid   = main_valid_r;
  assign bus.pc_reg      = main_r.pc;
  assign bus.rd1_reg     = main_r.rd1;
  assign bus.rd2_reg     = main_r.rd2;
  assign bus.imm_gen_reg = main_r.imm;
  assign bus.wr_reg      = main_r.wr;
  assign bus.ctrl_reg    = main_r.ctrl;
  assign stall_cnt       = stall_cnt_r;

  assign accept_s  = bus.in_valid & ~skid_valid_r;
  assign consume_s = main_valid_r & bus.out_ready;
  assign stall_s   = main_valid_r & ~bus.out_ready;

  // Next-state selection for the main/skid entries, keyed on {skid, main} valid
  always_comb begin
    main_nxt_s       = main_r;
    skid_nxt_s       = skid_r;
    main_valid_nxt_s = main_valid_r;
    skid_valid_nxt_s = skid_valid_r;
    if (flush) begin
      // Clearing ctrl keeps a squashed beat from ever presenting regwrite
      main_valid_nxt_s = 1'b0;
      skid_valid_nxt_s = 1'b0;
      main_nxt_s.ctrl  = '0;
      skid_nxt_s.ctrl  = '0;
    end else begin
      case ({skid_valid_r, main_valid_r})
        2'b00: begin
          if (accept_s) begin
            main_nxt_s       = in_beat_s;
            main_valid_nxt_s = 1'b1;
          end else begin
            main_valid_nxt_s = 1'b0;
          end
        end
        2'b01: begin
          if (accept_s && consume_s) begin
            main_nxt_s = in_beat_s;
          end else if (accept_s) begin
            skid_nxt_s       = in_beat_s;
            skid_valid_nxt_s = 1'b1;
          end else if (consume_s) begin
            main_valid_nxt_s = 1'b0;
          end else begin
            main_valid_nxt_s = 1'b1;
          end
        end
        2'b11: begin
          if (consume_s) begin
            main_nxt_s       = skid_r;
            skid_valid_nxt_s = 1'b0;
          end else begin
            skid_valid_nxt_s = 1'b1;
          end
        end
        default: begin
          // Skid valid without main valid is unreachable; recover to EMPTY
          main_valid_nxt_s = 1'b0;
          skid_valid_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // Entry storage and valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_r       <= '0;
      skid_r       <= '0;
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
    end else begin
      main_r       <= main_nxt_s;
      skid_r       <= skid_nxt_s;
      main_valid_r <= main_valid_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
    end
  end

  // Saturating stall counter; clear beats increment, flush leaves it alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= '0;
    end else if (stall_cnt_clr) begin
      stall_cnt_r <= '0;
    end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed checks on a default-width instance plus saturation and a scoreboard
// stream on a narrow instance (XLEN=32, CTRL_W=12, CNT_W=4).
module tb_id_ex_pipe_reg;
  localparam int NBEATS = 10000;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_a, clr_a, flush_b, clr_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
  int          n_cmp = 0;
  int          n_err = 0;

  id_ex_pipe_reg_if #(.XLEN(64), .WR_W(5), .CTRL_W(8))  ifa ();
  id_ex_pipe_reg_if #(.XLEN(32), .WR_W(5), .CTRL_W(12)) ifb ();

  id_ex_pipe_reg #(.XLEN(64), .WR_W(5), .CTRL_W(8), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave), .flush(flush_a),
    .stall_cnt_clr(clr_a), .stall_cnt(cnt_a));

  id_ex_pipe_reg #(.XLEN(32), .WR_W(5), .CTRL_W(12), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave), .flush(flush_b),
    .stall_cnt_clr(clr_b), .stall_cnt(cnt_b));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [63:0] p, input logic [7:0] c);
    ifa.in_valid = v;
    ifa.pc       = p;
    ifa.rd1      = p + 64'd1;
    ifa.rd2      = p + 64'd2;
    ifa.imm_gen  = p + 64'd3;
    ifa.wr       = p[4:0];
    ifa.ctrl     = c;
  endtask

  logic [144:0] q[$];
  logic [144:0] beat, obs, exp_v;
  int           sent, cyc;

  initial begin
    rst = 1'b1;
    flush_a = 1'b0; clr_a = 1'b0; flush_b = 1'b0; clr_b = 1'b0;
    drive_a(1'b0, 64'd0, 8'd0);
    ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.pc = 32'd0; ifb.rd1 = 32'd0; ifb.rd2 = 32'd0;
    ifb.imm_gen = 32'd0; ifb.wr = 5'd0; ifb.ctrl = 12'd0; ifb.out_ready = 1'b0;
    #2;
    check_eq("rst_out_valid", ifa.out_valid, 1'b0);
    check_eq("rst_in_ready", ifa.in_ready, 1'b1);
    check_eq("rst_pc_reg", ifa.pc_reg, 64'd0);
    check_eq("rst_stall_cnt", cnt_a, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Streaming with out_ready held high
    ifa.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, 64'h100 + 64'(4 * i), 8'h01);
      step();
      check_eq("stream_valid", ifa.out_valid, 1'b1);
      check_eq("stream_pc", ifa.pc_reg, 64'h100 + 64'(4 * i));
      check_eq("stream_rd2", ifa.rd2_reg, 64'h102 + 64'(4 * i));
      check_eq("stream_in_ready", ifa.in_ready, 1'b1);
    end
    drive_a(1'b0, 64'd0, 8'd0);
    step();
    check_eq("stream_drained", ifa.out_valid, 1'b0);
    check_eq("stream_stall_cnt", cnt_a, 16'd0);

    // Back-pressure: A to main, B to skid, C held off
    ifa.out_ready = 1'b0;
    drive_a(1'b1, 64'hA00, 8'h01);
    step();
    check_eq("bp_a_main", ifa.pc_reg, 64'hA00);
    check_eq("bp_one_ready", ifa.in_ready, 1'b1);
    drive_a(1'b1, 64'hB00, 8'h02);
    step();
    check_eq("bp_two_ready", ifa.in_ready, 1'b0);
    check_eq("bp_a_held", ifa.pc_reg, 64'hA00);
    check_eq("bp_cnt1", cnt_a, 16'd1);
    drive_a(1'b1, 64'hC00, 8'h03);
    step();
    check_eq("bp_c_blocked", ifa.pc_reg, 64'hA00);
    check_eq("bp_cnt2", cnt_a, 16'd2);
    ifa.out_ready = 1'b1;
    step();
    check_eq("bp_b_out", ifa.pc_reg, 64'hB00);
    check_eq("bp_b_ctrl", ifa.ctrl_reg, 8'h02);
    check_eq("bp_ready_back", ifa.in_ready, 1'b1);
    step();
    check_eq("bp_c_out", ifa.pc_reg, 64'hC00);
    check_eq("bp_c_wr", ifa.wr_reg, 5'd0);
    drive_a(1'b0, 64'd0, 8'd0);
    step();
    check_eq("bp_drained", ifa.out_valid, 1'b0);
    check_eq("bp_stall_total", cnt_a, 16'd2);

    // Flush while in TWO with a simultaneous incoming beat
    ifa.out_ready = 1'b0;
    drive_a(1'b1, 64'hD00, 8'hFF);
    step();
    drive_a(1'b1, 64'hE00, 8'hFF);
    step();
    drive_a(1'b1, 64'hF00, 8'hFF);
    flush_a = 1'b1;
    step();
    check_eq("fl2_out_valid", ifa.out_valid, 1'b0);
    check_eq("fl2_ctrl", ifa.ctrl_reg, 8'h00);
    check_eq("fl2_in_ready", ifa.in_ready, 1'b1);
    check_eq("fl2_cnt", cnt_a, 16'd4);
    flush_a = 1'b0;
    drive_a(1'b0, 64'd0, 8'd0);
    ifa.out_ready = 1'b1;
    step();
    check_eq("fl2_no_ghost", ifa.out_valid, 1'b0);

    // Flush while in ONE drops the accepted beat too
    ifa.out_ready = 1'b0;
    drive_a(1'b1, 64'h1100, 8'h81);
    step();
    drive_a(1'b1, 64'h1200, 8'h81);
    flush_a = 1'b1;
    step();
    flush_a = 1'b0;
    drive_a(1'b0, 64'd0, 8'd0);
    check_eq("fl1_out_valid", ifa.out_valid, 1'b0);
    check_eq("fl1_ctrl", ifa.ctrl_reg, 8'h00);
    step();
    check_eq("fl1_no_ghost", ifa.out_valid, 1'b0);
    check_eq("fl1_cnt", cnt_a, 16'd5);
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    check_eq("clr_cnt", cnt_a, 16'd0);

    // Asynchronous reset mid-cycle while holding two beats
    drive_a(1'b1, 64'h2100, 8'h11);
    step();
    drive_a(1'b1, 64'h2200, 8'h22);
    step();
    drive_a(1'b0, 64'd0, 8'd0);
    check_eq("pre_rst_two", ifa.in_ready, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mrst_out_valid", ifa.out_valid, 1'b0);
    check_eq("mrst_in_ready", ifa.in_ready, 1'b1);
    check_eq("mrst_pc_reg", ifa.pc_reg, 64'd0);
    check_eq("mrst_rd1_reg", ifa.rd1_reg, 64'd0);
    check_eq("mrst_ctrl_reg", ifa.ctrl_reg, 8'd0);
    check_eq("mrst_stall_cnt", cnt_a, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check_eq("post_rst_empty", ifa.out_valid, 1'b0);

    // Narrow instance: counter saturation at 15, then clear during a stall
    ifb.in_valid = 1'b1; ifb.pc = 32'h55; ifb.ctrl = 12'hABC;
    step();
    ifb.in_valid = 1'b0;
    repeat (20) step();
    check_eq("sat_cnt", cnt_b, 4'd15);
    check_eq("sat_ctrl", ifb.ctrl_reg, 12'hABC);
    clr_b = 1'b1;
    step();
    clr_b = 1'b0;
    check_eq("sat_clr_wins", cnt_b, 4'd0);
    step();
    check_eq("sat_resume", cnt_b, 4'd1);
    flush_b = 1'b1;
    step();
    flush_b = 1'b0;
    check_eq("b_flushed", ifb.out_valid, 1'b0);

    // Narrow instance: random valid/ready with an in-order scoreboard
    sent = 0;
    cyc  = 0;
    while ((sent < NBEATS || q.size() != 0) && cyc < 80000) begin
      ifb.in_valid  = (sent < NBEATS) && ($urandom_range(0, 9) < 7);
      ifb.pc        = 32'(sent);
      ifb.rd1       = $urandom;
      ifb.rd2       = $urandom;
      ifb.imm_gen   = $urandom;
      ifb.wr        = 5'($urandom);
      ifb.ctrl      = 12'($urandom);
      ifb.out_ready = ($urandom_range(0, 9) < 6);
      beat = {ifb.pc, ifb.rd1, ifb.rd2, ifb.imm_gen, ifb.wr, ifb.ctrl};
      #1;
      if (ifb.out_valid && ifb.out_ready) begin
        obs = {ifb.pc_reg, ifb.rd1_reg, ifb.rd2_reg, ifb.imm_gen_reg, ifb.wr_reg, ifb.ctrl_reg};
        if (q.size() != 0) exp_v = q.pop_front();
        else exp_v = ~obs;
        check_eq("sb_beat", obs, exp_v);
      end
      if (ifb.in_valid && ifb.in_ready) begin
        q.push_back(beat);
        sent++;
      end
      step();
      cyc++;
    end
    check_eq("sb_sent", sent, NBEATS);
    check_eq("sb_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
